// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_arbiter
//  Purpose  : Shares one memory port between the CPU instruction-fetch (IF)
//             and data-memory (DM) masters. Round-robin arbitration with a
//             single outstanding transaction; the response is routed back to
//             the master that owns the current transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  riscv_cpu_clk,
  input  logic                  riscv_cpu_reset,
  // instruction-fetch master
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_req_addr,
  output logic                  if_rsp_valid,
  input  logic                  if_rsp_ready,
  output logic [DATA_W-1:0]     if_rsp_data,
  // data-memory master
  input  logic                  dm_req_valid,
  output logic                  dm_req_ready,
  input  logic [ADDR_W-1:0]     dm_req_addr,
  input  logic                  dm_req_wen,
  input  logic [DATA_W-1:0]     dm_req_wdata,
  input  logic [DATA_W/8-1:0]   dm_req_wstrb,
  output logic                  dm_rsp_valid,
  input  logic                  dm_rsp_ready,
  output logic [DATA_W-1:0]     dm_rsp_data,
  // shared memory port
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [DATA_W-1:0]     mem_rsp_data,
  output logic                  grant_dm
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last_grant_dm;
  logic                  r_grant_dm;
  logic                  r_mem_req_valid;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic                  r_mem_wen;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [DATA_W/8-1:0]   r_mem_wstrb;

  logic                  w_in_idle;
  logic                  w_in_resp;
  logic                  w_dm_win;
  logic                  w_if_win;

  // Readys are gated by the reset level so nothing is accepted while reset
  // is held, even though the state register already sits in IDLE.
  assign w_in_idle = (r_state == ST_IDLE) && riscv_cpu_reset;
  assign w_in_resp = (r_state == ST_RESP);

  // DM wins when it is alone, or on a tie when IF was served last.
  assign w_dm_win  = dm_req_valid && (!if_req_valid || !r_last_grant_dm);
  assign w_if_win  = if_req_valid && !w_dm_win;

  assign if_req_ready  = w_in_idle && w_if_win;
  assign dm_req_ready  = w_in_idle && w_dm_win;

  // Response path is purely combinational so memory data reaches the owner
  // in the same cycle; the non-owner never sees a valid.
  assign if_rsp_valid  = w_in_resp && !r_grant_dm && mem_rsp_valid;
  assign dm_rsp_valid  = w_in_resp &&  r_grant_dm && mem_rsp_valid;
  assign if_rsp_data   = mem_rsp_data;
  assign dm_rsp_data   = mem_rsp_data;
  assign mem_rsp_ready = w_in_resp && (r_grant_dm ? dm_rsp_ready : if_rsp_ready);

  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_wen       = r_mem_wen;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wstrb     = r_mem_wstrb;
  assign grant_dm      = r_grant_dm;

  // Transaction FSM: latch the winner, hold the request until memory takes
  // it, then wait for the owner to consume the response.
  always_ff @(posedge riscv_cpu_clk or negedge riscv_cpu_reset) begin
    if (!riscv_cpu_reset) begin
      r_state         <= ST_IDLE;
      r_last_grant_dm <= 1'b1;
      r_grant_dm      <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wstrb     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_dm_win) begin
            r_mem_addr      <= dm_req_addr;
            r_mem_wen       <= dm_req_wen;
            r_mem_wdata     <= dm_req_wdata;
            r_mem_wstrb     <= dm_req_wstrb;
            r_grant_dm      <= 1'b1;
            r_last_grant_dm <= 1'b1;
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_REQ;
          end else if (w_if_win) begin
            // Fetches are always reads with no write payload.
            r_mem_addr      <= if_req_addr;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wstrb     <= '0;
            r_grant_dm      <= 1'b0;
            r_last_grant_dm <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_rsp_valid && mem_rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state         <= ST_IDLE;
          r_mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mem_arbiter
//  Purpose  : Directed self-checking bench for riscv_mem_arbiter with a
//             scoreboard of accepted requests and a behavioural memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        dm_req_valid, dm_req_ready, dm_req_wen, dm_rsp_valid, dm_rsp_ready;
  logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_data;
  logic [3:0]  dm_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wstrb;
  logic        grant_dm;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .riscv_cpu_clk(clk), .riscv_cpu_reset(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_req_wen(dm_req_wen), .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_ready(dm_rsp_ready), .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .grant_dm(grant_dm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   dm_pulses = 0;
  logic exp_last_dm;

  // Count completed DM response handshakes.
  always @(posedge clk) if (dm_rsp_valid && dm_rsp_ready) dm_pulses++;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'h5A5A_0F0F);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge with request inputs set; expects an accept.
  task automatic do_accept();
    logic exp_dm;
    txn_t t;
    @(negedge clk);
    exp_dm = dm_req_valid && (!if_req_valid || !exp_last_dm);
    chk("if_req_ready", if_req_ready, if_req_valid && !exp_dm);
    chk("dm_req_ready", dm_req_ready, exp_dm);
    t.dm    = exp_dm;
    t.addr  = exp_dm ? dm_req_addr  : if_req_addr;
    t.wen   = exp_dm ? dm_req_wen   : 1'b0;
    t.wdata = exp_dm ? dm_req_wdata : 32'h0;
    t.wstrb = exp_dm ? dm_req_wstrb : 4'h0;
    t.rdata = t.wen ? 32'h0 : mem_model(t.addr);
    sb.push_back(t);
    exp_last_dm = exp_dm;
    step();
    chk("grant_dm", grant_dm, exp_dm);
    chk("mem_req_valid_on_accept", mem_req_valid, 1'b1);
  endtask

  // Plays memory for the transaction at the scoreboard head.
  task automatic serve(input int wait_req, input int wait_rsp, input int hold);
    txn_t t;
    t = sb[0];
    for (int i = 0; i <= wait_req; i++) begin
      mem_req_ready = (i == wait_req);
      @(negedge clk);
      chk("mem_req_valid", mem_req_valid, 1'b1);
      chk("mem_addr", mem_addr, t.addr);
      chk("mem_wen", mem_wen, t.wen);
      chk("mem_wdata", mem_wdata, t.wdata);
      chk("mem_wstrb", mem_wstrb, t.wstrb);
      chk("req_ready_busy", {if_req_ready, dm_req_ready}, 2'b00);
      step();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < wait_rsp; i++) begin
      @(negedge clk);
      chk("mem_req_valid_resp", mem_req_valid, 1'b0);
      chk("rsp_valid_wait", {if_rsp_valid, dm_rsp_valid}, 2'b00);
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = t.rdata;
    if_rsp_ready  = t.dm;
    dm_rsp_ready  = !t.dm;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("mem_rsp_ready_hold", mem_rsp_ready, 1'b0);
      chk("owner_valid_hold", t.dm ? dm_rsp_valid : if_rsp_valid, 1'b1);
      chk("req_ready_hold", {if_req_ready, dm_req_ready}, 2'b00);
      step();
    end
    if_rsp_ready = 1'b1;
    dm_rsp_ready = 1'b1;
    @(negedge clk);
    chk("owner_rsp_valid", t.dm ? dm_rsp_valid : if_rsp_valid, 1'b1);
    chk("owner_rsp_data", t.dm ? dm_rsp_data : if_rsp_data, t.rdata);
    chk("other_rsp_valid", t.dm ? if_rsp_valid : dm_rsp_valid, 1'b0);
    chk("mem_rsp_ready", mem_rsp_ready, 1'b1);
    chk("grant_owner", grant_dm, t.dm);
    void'(sb.pop_front());
    step();
    mem_rsp_valid = 1'b0;
    if_rsp_ready  = 1'b0;
    dm_rsp_ready  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; exp_last_dm = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    dm_req_valid = 1'b1; dm_req_addr = 32'h2000_0000; dm_req_wen = 1'b0;
    dm_req_wdata = 32'h0; dm_req_wstrb = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    if_rsp_ready = 1'b0; dm_rsp_ready = 1'b0;

    // 1: reset held with both requesters valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", {if_req_ready, dm_req_ready}, 2'b00);
      chk("rst_valids", {mem_req_valid, mem_rsp_ready, if_rsp_valid, dm_rsp_valid}, 4'h0);
      chk("rst_grant", grant_dm, 1'b0);
      chk("rst_payload", {mem_addr, mem_wen, mem_wstrb}, 37'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // 2: IF wins the first tie; read of address 0 with 2 response waits
    do_accept();
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    serve(0, 2, 0);

    // 3: DM write held off by memory for 4 cycles
    dm_pulses = 0;
    dm_req_valid = 1'b1; dm_req_addr = 32'h1000_0004; dm_req_wen = 1'b1;
    dm_req_wdata = 32'hDEAD_BEEF; dm_req_wstrb = 4'hF;
    do_accept();
    dm_req_valid = 1'b0;
    serve(4, 0, 0);
    chk("dm_write_pulses", dm_pulses, 1);

    // 4: both masters valid for 6 transactions -> strict alternation
    if_req_addr = 32'h0000_0040; if_req_valid = 1'b1;
    dm_req_addr = 32'h3000_0008; dm_req_wen = 1'b0; dm_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_accept();
      chk("rr_order", grant_dm, (i % 2) == 1);
      serve(0, 0, 0);
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;

    // 5: owner stalls the response for 3 cycles while IF waits
    dm_req_addr = 32'h3000_0100; dm_req_valid = 1'b1;
    do_accept();
    dm_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h0000_0200;
    serve(1, 0, 3);
    do_accept();
    if_req_valid = 1'b0;
    serve(0, 0, 0);

    // 6: reset while a request is pending at memory
    if_req_addr = 32'h0000_0300; if_req_valid = 1'b1;
    do_accept();
    if_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("mid_rst_grant", grant_dm, 1'b0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    sb.delete();
    exp_last_dm = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    if_req_valid = 1'b1; dm_req_valid = 1'b1; dm_req_addr = 32'h3000_0400;
    do_accept();
    if_req_valid = 1'b0;
    serve(0, 1, 0);
    do_accept();
    dm_req_valid = 1'b0;
    serve(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
